ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the mini RISC-V core, directly upstream of the memory stage.
- Takes decoded operands and control from ID/EX and computes the ALU result and memory address.
- Handles RV32M multiply/divide with an iterative unit.
- Registers the result plus passthrough control (MemRead, MemWrite, MemtoReg, RegWrite, rd, store data) into the EX/MEM boundary consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width; all operand and result widths.
- MULDIV_CYCLES, 32, iterations of the multi-cycle unit; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  ID/EX presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  5  operation code (package enum).
- op_a  in  XLEN  operand A (rs1 or PC).
- op_b  in  XLEN  operand B (rs2 or immediate).
- store_data  in  XLEN  rs2 value for stores.
- rd  in  5  destination register.
- mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control passthrough.
- stall_in  in  1  downstream hold; EX/MEM outputs must not change.
- flush  in  1  kill the in-flight instruction (branch mispredict).
- out_valid  out  1  EX/MEM register holds a valid instruction.
- alu_result  out  XLEN  result / effective address.
- store_data_out  out  XLEN  registered store_data.
- rd_out  out  5  registered rd.
- mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out  out  1 each  registered control.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Reset (rst==0 at a rising edge): all outputs 0, FSM to IDLE, iteration counter 0. Applies mid-operation; the partial result is discarded.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && !stall_in.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI passthrough of op_b):
  - Result is registered at the accepting edge; out_valid=1 the next cycle (latency 1).
  - Shifts use op_b[4:0].
  - SLT is signed; SLTU is unsigned.
  - Arithmetic wraps modulo 2^XLEN.
- MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU:
  - The accepting edge latches operands and control, and the FSM goes IDLE->BUSY with busy=1.
  - The unit runs one iteration per cycle for MULDIV_CYCLES cycles.
  - The FSM then enters DONE, which writes the EX/MEM register; out_valid rises MULDIV_CYCLES+1 cycles after acceptance.
  - The FSM returns to IDLE on the cycle after DONE.
  - While BUSY, out_valid=0 (bubble to the memory stage).
- Signed mul/div: operate on magnitudes; fix the sign at the end.
- Division by zero: quotient = all ones; remainder = dividend. The full iteration count still runs, so latency is fixed.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- stall_in:
  - All EX/MEM outputs hold their values; no accept.
  - In BUSY, iterations continue.
  - DONE waits in DONE until stall_in==0, then writes.
- flush:
  - Takes priority over accept and stall.
  - At that edge out_valid<=0, mem_write_out<=0, reg_write_out<=0.
  - FSM returns to IDLE and any BUSY operation is abandoned.
  - If in_valid and flush are high together, the instruction is not accepted.
- When no accept occurs and stall_in==0, the next edge sets out_valid<=0; the data outputs are left unchanged.

Optional Feature:
- FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU are single-cycle, using a combinational 33x33 signed product; latency 1, busy stays 0.
  - Divide remains iterative.
- Not defined: multiplies use the iterative shift-add path with the same latency as divide.

Decomposition:
- Package ex_pkg:
  - alu_op enum (5-bit encodings).
  - FSM state enum {IDLE, BUSY, DONE}.
  - XLEN constant.
  - Constants DIV0_QUOT = all ones and INT_MIN.
- One sub-module, muldiv_iter: iterative multiply/divide engine with start/done handshake. It holds the counter, the accumulator/remainder and the sign fix-up. ex_stage holds the ALU, the FSM and the EX/MEM register.

Test Plan:
- ADD 0x7FFFFFFF + 1 with mem_read=1, rd=5: next cycle alu_result=0x80000000, out_valid=1, mem_read_out=1, rd_out=5.
- DIVU 100/7: busy high for 32 cycles; alu_result=14 at acceptance+33; REMU gives 2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- DIV -7/2 with stall_in held high for 5 cycles in DONE: outputs frozen, then alu_result=0xFFFFFFFD (-3). Repeat with REM -> 0xFFFFFFFF.
- MUL in BUSY, flush at cycle 10: out_valid stays 0, in_ready=1 on the next cycle, and a following ADD completes normally.
- rst=0 during BUSY: next cycle all outputs 0, busy=0. A valid MULHU 0xFFFFFFFF*0xFFFFFFFF after reset gives 0xFFFFFFFE. Under FAST_MUL_EN this result appears at latency 1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, FSM states, EX/MEM bundle.
// FAST_MUL_EN selects single-cycle multiplies in ex_stage.
package ex_pkg;

  localparam int XLEN = 32;
  localparam int MULDIV_CYCLES = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN-1:0] INT_MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    AND    = 5'd2,
    OR     = 5'd3,
    XOR    = 5'd4,
    SLL    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    SLT    = 5'd8,
    SLTU   = 5'd9,
    LUI    = 5'd10,
    MUL    = 5'd16,
    MULH   = 5'd17,
    MULHSU = 5'd18,
    MULHU  = 5'd19,
    DIV    = 5'd20,
    DIVU   = 5'd21,
    REM    = 5'd22,
    REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
  } ex_mem_t;

  function automatic logic is_div_op(alu_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_mul_op(alu_op_e op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply, restoring divide,
// magnitudes internally with sign fix-up on the result.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int MULDIV_CYCLES = ex_pkg::MULDIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MULDIV_CYCLES);

  alu_op_e         op_q;
  logic            run;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dvs;
  logic            div_q;
  logic            neg_p;
  logic            neg_r;
  logic            div0;
  logic            ovf;

  logic            sgn_a;
  logic            sgn_b;
  logic            na;
  logic            nb;
  logic            div_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic            ge;
  logic [XLEN-1:0] diff;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  assign sgn_a  = op inside {MULH, MULHSU, DIV, REM};
  assign sgn_b  = op inside {MULH, DIV, REM};
  assign na     = sgn_a && a[XLEN-1];
  assign nb     = sgn_b && b[XLEN-1];
  assign mag_a  = na ? (XLEN'(0) - a) : a;
  assign mag_b  = nb ? (XLEN'(0) - b) : b;
  assign div_in = is_div_op(op);

  assign done = run && (cnt == CW'(MULDIV_CYCLES - 1));

  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
    shl  = {acc, lo[XLEN-1]};
    ge   = shl >= {1'b0, dvs};
    diff = shl[XLEN-1:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q  <= ADD;
      run   <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      lo    <= '0;
      dvs   <= '0;
      div_q <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      op_q  <= op;
      run   <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      lo    <= div_in ? mag_a : mag_b;
      dvs   <= div_in ? mag_b : mag_a;
      div_q <= div_in;
      neg_p <= na ^ nb;
      neg_r <= na;
      div0  <= (b == '0);
      ovf   <= (op == DIV) && (a == INT_MIN)
               && (b == '1);
    end else if (run) begin
      if (div_q) begin
        acc <= ge ? diff : shl[XLEN-1:0];
        lo  <= {lo[XLEN-2:0], ge};
      end else begin
        {acc, lo} <= {sum, lo[XLEN-1:1]};
      end
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  // Quotient of a divide by zero ignores the sign fix-up.
  always_comb begin
    prod = neg_p ? ('0 - {acc, lo}) : {acc, lo};
    quot = neg_p ? (XLEN'(0) - lo) : lo;
    rem  = neg_r ? (XLEN'(0) - acc) : acc;
    result = '0;
    unique case (op_q)
      MUL:    result = prod[XLEN-1:0];
      MULH,
      MULHSU,
      MULHU:  result = prod[2*XLEN-1:XLEN];
      DIV,
      DIVU:   result = div0 ? DIV0_QUOT
                     : ovf ? INT_MIN : quot;
      REM,
      REMU:   result = rem;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, RV32M sequencing FSM and the EX/MEM register.
// FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MULDIV_CYCLES = ex_pkg::MULDIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            stall_in,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            mem_to_reg_out,
  output logic            reg_write_out,
  output logic            busy
);

  state_e          state;
  state_e          state_n;
  ex_mem_t         q;
  ex_mem_t         ctl;
  ex_mem_t         ctl_in;
  logic            accept;
  logic            is_iter;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] alu_res;

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     fa;
  logic signed [XLEN:0]     fb;
  logic signed [2*XLEN-1:0] fp;

  assign fa = {(alu_op == MULHU) ? 1'b0 : op_a[XLEN-1], op_a};
  assign fb = {(alu_op inside {MULHU, MULHSU})
               ? 1'b0 : op_b[XLEN-1], op_b};
  assign fp = (2*XLEN)'(fa) * (2*XLEN)'(fb);
  assign is_iter = is_div_op(alu_op);
`else
  assign is_iter = is_div_op(alu_op)
                 | is_mul_op(alu_op);
`endif

  assign in_ready = (state == IDLE) && !stall_in;
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state == BUSY);

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ADD:  alu_res = op_a + op_b;
      SUB:  alu_res = op_a - op_b;
      AND:  alu_res = op_a & op_b;
      OR:   alu_res = op_a | op_b;
      XOR:  alu_res = op_a ^ op_b;
      SLL:  alu_res = op_a << op_b[4:0];
      SRL:  alu_res = op_a >> op_b[4:0];
      SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
      SLT:  alu_res = {{(XLEN-1){1'b0}},
                       $signed(op_a) < $signed(op_b)};
      SLTU: alu_res = {{(XLEN-1){1'b0}},
                       op_a < op_b};
      LUI:  alu_res = op_b;
`ifdef FAST_MUL_EN
      MUL:  alu_res = fp[XLEN-1:0];
      MULH,
      MULHSU,
      MULHU: alu_res = fp[2*XLEN-1:XLEN];
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ctl_in            = '0;
    ctl_in.valid      = 1'b1;
    ctl_in.result     = alu_res;
    ctl_in.store_data = store_data;
    ctl_in.rd         = rd;
    ctl_in.mem_read   = mem_read;
    ctl_in.mem_write  = mem_write;
    ctl_in.mem_to_reg = mem_to_reg;
    ctl_in.reg_write  = reg_write;
  end

  muldiv_iter #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_iter),
    .kill   (flush),
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_iter) state_n = BUSY;
      BUSY: if (md_done) state_n = DONE;
      DONE: if (!stall_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Data fields hold on bubbles; only valid drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= '0;
      ctl <= '0;
    end else begin
      if (accept) ctl <= ctl_in;
      if (flush) begin
        q.valid     <= 1'b0;
        q.mem_write <= 1'b0;
        q.reg_write <= 1'b0;
      end else if (!stall_in) begin
        if (state == DONE) begin
          q        <= ctl;
          q.result <= md_result;
          q.valid  <= 1'b1;
        end else if (accept && !is_iter) begin
          q <= ctl_in;
        end else begin
          q.valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid      = q.valid;
  assign alu_result     = q.result;
  assign store_data_out = q.store_data;
  assign rd_out         = q.rd;
  assign mem_read_out   = q.mem_read;
  assign mem_write_out  = q.mem_write;
  assign mem_to_reg_out = q.mem_to_reg;
  assign reg_write_out  = q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, RV32M latency/corners,
// stall, flush and reset; honours FAST_MUL_EN.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  alu_op_e     alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        stall_in;
  logic        flush;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data_out;
  logic [4:0]  rd_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_op         (alu_op),
    .op_a           (op_a),
    .op_b           (op_b),
    .store_data     (store_data),
    .rd             (rd),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
    .stall_in       (stall_in),
    .flush          (flush),
    .out_valid      (out_valid),
    .alu_result     (alu_result),
    .store_data_out (store_data_out),
    .rd_out         (rd_out),
    .mem_read_out   (mem_read_out),
    .mem_write_out  (mem_write_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out),
    .busy           (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_e op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic run_md(input alu_op_e op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input string tag);
    drive(op, a, b);
    rd = 5'd9;
    step();
    in_valid = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_bubble"}, out_valid, 0);
    repeat (31) step();
    check({tag, "_busy31"}, busy, 1);
    step();
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_vld"}, out_valid, 0);
    step();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, alu_result, exp);
    check({tag, "_rd"}, rd_out, 9);
  endtask

  task automatic run_mul(input alu_op_e op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input string tag);
`ifdef FAST_MUL_EN
    drive(op, a, b);
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, alu_result, exp);
`else
    run_md(op, a, b, exp, tag);
`endif
  endtask

  task automatic md_stall(input alu_op_e op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp,
                          input logic [31:0] prev,
                          input string tag);
    drive(op, a, b);
    step();
    in_valid = 1'b0;
    repeat (32) step();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check({tag, "_hold_vld"}, out_valid, 0);
      check({tag, "_hold_res"}, alu_result, prev);
    end
    stall_in = 1'b0;
    step();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, alu_result, exp);
  endtask

  alu_op_e     t_op [11];
  logic [31:0] t_a  [11];
  logic [31:0] t_b  [11];
  logic [31:0] t_r  [11];

  initial begin
    t_op = '{SUB, AND, OR, XOR, SLL, SRL,
             SRA, SLT, SLTU, LUI, ADD};
    t_a  = '{32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0,
             32'hF0F0F0F0, 32'h1, 32'h80000000,
             32'h80000000, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    t_b  = '{32'h1, 32'hFF00FF00, 32'hFF00FF00,
             32'hFF00FF00, 32'h21, 32'h1F,
             32'h3F, 32'h1, 32'h1, 32'hABCDE000,
             32'h1};
    t_r  = '{32'hFFFFFFFF, 32'hF000F000,
             32'hFFF0FFF0, 32'h0FF00FF0, 32'h2,
             32'h1, 32'hFFFFFFFF, 32'h1, 32'h0,
             32'hABCDE000, 32'h0};

    rst = 1'b0;
    in_valid = 1'b0;
    alu_op = ADD;
    op_a = '0;
    op_b = '0;
    store_data = '0;
    rd = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    step();
    step();
    check("rst_vld", out_valid, 0);
    check("rst_res", alu_result, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 1);
    rst = 1'b1;
    step();

    drive(ADD, 32'h7FFFFFFF, 32'h1);
    mem_read = 1'b1;
    rd = 5'd5;
    store_data = 32'h1234;
    step();
    in_valid = 1'b0;
    mem_read = 1'b0;
    check("add_vld", out_valid, 1);
    check("add_res", alu_result, 32'h80000000);
    check("add_mrd", mem_read_out, 1);
    check("add_rd", rd_out, 5);
    check("add_sd", store_data_out, 32'h1234);
    step();
    check("bubble_vld", out_valid, 0);
    check("bubble_res", alu_result, 32'h80000000);

    for (int i = 0; i < 11; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      step();
      check($sformatf("alu%0d_vld", i), out_valid, 1);
      check($sformatf("alu%0d_res", i),
            alu_result, t_r[i]);
    end
    in_valid = 1'b0;

    stall_in = 1'b1;
    drive(ADD, 32'h1, 32'h1);
    #1;
    check("stall_rdy", in_ready, 0);
    step();
    check("stall_vld", out_valid, 1);
    check("stall_res", alu_result, 32'h0);
    stall_in = 1'b0;
    in_valid = 1'b0;
    step();
    check("unstall_vld", out_valid, 0);
    check("unstall_res", alu_result, 32'h0);

    drive(ADD, 32'h1, 32'h1);
    reg_write = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flacc_vld", out_valid, 0);
    check("flacc_rw", reg_write_out, 0);
    check("flacc_res", alu_result, 32'h0);

    run_md(DIVU, 32'd100, 32'd7, 32'd14, "divu");
    run_md(REMU, 32'd100, 32'd7, 32'd2, "remu");
    run_md(DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, "div_ovf");
    run_md(REM, 32'h80000000, 32'hFFFFFFFF,
           32'h0, "rem_ovf");
    run_md(DIV, 32'd5, 32'd0, 32'hFFFFFFFF, "div0");
    run_md(REM, 32'd5, 32'd0, 32'd5, "rem0");
    check("rw_pass", reg_write_out, 1);

    md_stall(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD,
             32'd5, "div_stall");
    md_stall(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF,
             32'hFFFFFFFD, "rem_stall");

`ifdef FAST_MUL_EN
    drive(DIVU, 32'd3, 32'd4);
`else
    drive(MUL, 32'd3, 32'd4);
`endif
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("fl_busy_pre", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_rw", reg_write_out, 0);
    check("fl_busy", busy, 0);
    check("fl_rdy", in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        step();
        seen = seen | out_valid | busy;
      end
      check("fl_quiet", seen, 0);
    end
    drive(ADD, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    check("fl_add_vld", out_valid, 1);
    check("fl_add_res", alu_result, 32'd7);

    drive(DIVU, 32'd100, 32'd7);
    store_data = 32'hCAFE;
    mem_write = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mem_write = 1'b0;
    check("mrst_vld", out_valid, 0);
    check("mrst_res", alu_result, 0);
    check("mrst_sd", store_data_out, 0);
    check("mrst_rd", rd_out, 0);
    check("mrst_rw", reg_write_out, 0);
    check("mrst_mw", mem_write_out, 0);
    check("mrst_busy", busy, 0);
    repeat (40) step();
    check("mrst_quiet", out_valid, 0);

    run_mul(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, "mulhu");
    run_mul(MUL, 32'hFFFFFFFD, 32'd5,
            32'hFFFFFFF1, "mul_neg");
    run_mul(MULH, 32'hFFFFFFFF, 32'd2,
            32'hFFFFFFFF, "mulh");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
